morse_encoder: RTL and testbench

- Transmit-side counterpart of the Morse decoder path.
- Accepts one Morse symbol per valid/ready handshake and drives a single keying line (key_out) with standard Morse timing: dot = 1 unit, dash = 3, intra-letter gap = 1, letter gap = 3, word gap = 7.
- One time unit is UNIT_TICKS cycles of clk_100Mhz.
- Used to generate keying stimulus for the decoder and to drive an LED or buzzer output.

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_unit_timer.sv | 35 +++
 rtl/morse_encoder.sv | 135 +++++++++++++
 tb/tb_morse_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse state encoding and element/gap lengths in units.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      GAP_ELEM,
      GAP_END
   } morse_tx_state_t;

   localparam logic [2:0] DOT_UNITS        = 3'd1;
   localparam logic [2:0] DASH_UNITS       = 3'd3;
   localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
   localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
   localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - reloadable divider producing one unit_tick per UNIT_TICKS cycles.
module morse_unit_timer #(
   parameter int UNIT_TICKS = 5_000_000
) (
   input  logic clk_100Mhz,
   input  logic reset,
   input  logic restart,
   output logic unit_tick
);

   localparam int CNT_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(UNIT_TICKS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign unit_tick = (cnt_q == '0);

   // restart aligns the first tick of a new phase to a full unit
   always_comb begin
      if (restart || unit_tick) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - accepts one Morse symbol per handshake and keys it out with unit timing.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_TICKS = 5_000_000,
   parameter int MAX_ELEMS  = 5
) (
   input  logic                 clk_100Mhz,
   input  logic                 reset,
   input  logic                 sym_valid,
   output logic                 sym_ready,
   input  logic [2:0]           sym_len,
   input  logic [MAX_ELEMS-1:0] sym_bits,
   input  logic                 sym_word_gap,
   output logic                 key_out,
   output logic                 busy
);

   localparam int IDX_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
   localparam logic [2:0] MAX_LEN = 3'(MAX_ELEMS);

   morse_tx_state_t      state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [2:0]           len_q, len_d;
   logic [MAX_ELEMS-1:0] bits_q, bits_d;
   logic                 word_gap_q, word_gap_d;
   logic [2:0]           units_q, units_d;
   logic                 key_out_q, key_out_d;
   logic                 sym_ready_q, sym_ready_d;

   logic                 restart;
   logic                 unit_tick;
   logic                 phase_end;
   logic [2:0]           len_clamped;
   logic [2:0]           idx_ext;
   logic [IDX_W-1:0]     idx_next;

   morse_unit_timer #(.UNIT_TICKS(UNIT_TICKS)) u_timer (
      .clk_100Mhz (clk_100Mhz),
      .reset      (reset),
      .restart    (restart),
      .unit_tick  (unit_tick)
   );

   assign len_clamped = (sym_len > MAX_LEN) ? MAX_LEN : sym_len;
   assign idx_ext     = 3'(idx_q);
   assign idx_next    = idx_q + IDX_W'(1);
   assign phase_end   = unit_tick && (units_q == 3'd1);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      len_d      = len_q;
      bits_d     = bits_q;
      word_gap_d = word_gap_q;
      units_d    = (unit_tick && units_q > 3'd1) ? units_q - 3'd1 : units_q;
      restart    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sym_valid && sym_ready_q) begin
               restart    = 1'b1;
               idx_d      = '0;
               len_d      = len_clamped;
               bits_d     = sym_bits;
               word_gap_d = sym_word_gap;
               if (len_clamped != 3'd0) begin
                  state_d = MARK;
                  units_d = sym_bits[0] ? DASH_UNITS : DOT_UNITS;
               end else begin
                  state_d = GAP_END;
                  units_d = sym_word_gap ? WORD_GAP_UNITS : LETTER_GAP_UNITS;
               end
            end
         end
         MARK: begin
            if (phase_end) begin
               restart = 1'b1;
               if (idx_ext == len_q - 3'd1) begin
                  state_d = GAP_END;
                  units_d = word_gap_q ? WORD_GAP_UNITS : LETTER_GAP_UNITS;
               end else begin
                  state_d = GAP_ELEM;
                  units_d = ELEM_GAP_UNITS;
               end
            end
         end
         GAP_ELEM: begin
            if (phase_end) begin
               restart = 1'b1;
               idx_d   = idx_next;
               state_d = MARK;
               units_d = bits_q[idx_next] ? DASH_UNITS : DOT_UNITS;
            end
         end
         GAP_END: begin
            if (phase_end) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // outputs follow the next state so they are registered alongside it
      key_out_d   = (state_d == MARK);
      sym_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         bits_q      <= '0;
         word_gap_q  <= 1'b0;
         units_q     <= '0;
         key_out_q   <= 1'b0;
         sym_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         bits_q      <= bits_d;
         word_gap_q  <= word_gap_d;
         units_q     <= units_d;
         key_out_q   <= key_out_d;
         sym_ready_q <= sym_ready_d;
      end
   end

   assign key_out   = key_out_q;
   assign sym_ready = sym_ready_q;
   assign busy      = ~sym_ready_q;

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - scoreboard bench: expected per-cycle key/busy stream checked by a monitor.
module tb_morse_encoder;

   localparam int U    = 4;
   localparam int MAXE = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sym_valid = 1'b0;
   logic        sym_ready;
   logic [2:0]  sym_len = '0;
   logic [4:0]  sym_bits = '0;
   logic        sym_word_gap = 1'b0;
   logic        key_out;
   logic        busy;

   typedef struct {
      logic key;
      logic busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;

   always #5 clk = ~clk;

   morse_encoder #(.UNIT_TICKS(U), .MAX_ELEMS(MAXE)) dut (
      .clk_100Mhz   (clk),
      .reset        (reset),
      .sym_valid    (sym_valid),
      .sym_ready    (sym_ready),
      .sym_len      (sym_len),
      .sym_bits     (sym_bits),
      .sym_word_gap (sym_word_gap),
      .key_out      (key_out),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_run(input logic key, input int cycles);
      for (int c = 0; c < cycles; c++) exp_q.push_back('{key: key, busy: 1'b1});
   endtask

   // Reference: element/gap lengths straight from Morse timing, then one ready cycle.
   task automatic push_expected(input logic [2:0] len, input logic [4:0] bits, input logic wg);
      int n;
      n = (int'(len) > MAXE) ? MAXE : int'(len);
      for (int i = 0; i < n; i++) begin
         push_run(1'b1, (bits[i] ? 3 : 1) * U);
         if (i < n - 1) push_run(1'b0, U);
      end
      push_run(1'b0, (wg ? 7 : 3) * U);
      exp_q.push_back('{key: 1'b0, busy: 1'b0});
   endtask

   task automatic send(input logic [2:0] len, input logic [4:0] bits, input logic wg, input bit hold);
      int waited;
      waited       = 0;
      sym_valid    = 1'b1;
      sym_len      = len;
      sym_bits     = bits;
      sym_word_gap = wg;
      @(negedge clk);
      while (!sym_ready) begin
         waited++;
         if (waited > 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: sym_ready never rose, expected within 1000 cycles");
            sym_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      push_expected(len, bits, wg);
      sym_len      = 3'($urandom);
      sym_bits     = 5'($urandom);
      sym_word_gap = 1'($urandom);
      if (!hold) sym_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("key_out", key_out, e.key);
            chk("busy", busy, e.busy);
            chk("sym_ready", sym_ready, ~e.busy);
         end else begin
            chk("idle_key_out", key_out, 1'b0);
            chk("idle_busy", busy, 1'b0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_key_out", key_out, 1'b0);
      chk("reset_sym_ready", sym_ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      reset  = 1'b0;
      mon_en = 1'b1;
      idle_cycles(2);

      // E, A, word space, letter space
      send(3'd1, 5'b00000, 1'b0, 1'b0);
      idle_cycles(30);
      send(3'd2, 5'b00010, 1'b0, 1'b0);
      idle_cycles(40);
      send(3'd0, 5'b00000, 1'b1, 1'b0);
      idle_cycles(35);
      send(3'd0, 5'b00000, 1'b0, 1'b0);
      idle_cycles(20);

      // T then E with sym_valid held high
      send(3'd1, 5'b00001, 1'b0, 1'b1);
      send(3'd1, 5'b00000, 1'b0, 1'b0);
      idle_cycles(25);

      // reset mid-dash of T: reset high during cycle T+6
      send(3'd1, 5'b00001, 1'b0, 1'b0);
      idle_cycles(5);
      reset = 1'b1;
      idle_cycles(1);
      reset = 1'b0;
      exp_q.delete();
      idle_cycles(3);
      send(3'd1, 5'b00000, 1'b0, 1'b0);
      idle_cycles(25);

      // reset and sym_valid together: nothing accepted
      sym_valid = 1'b1;
      sym_len   = 3'd1;
      sym_bits  = 5'b00001;
      reset     = 1'b1;
      idle_cycles(1);
      reset     = 1'b0;
      sym_valid = 1'b0;
      idle_cycles(5);

      // clamp: len 7 with all dashes
      send(3'd7, 5'b11111, 1'b0, 1'b0);
      sym_len  = 3'd1;
      sym_bits = 5'b00000;
      idle_cycles(120);

      for (int k = 0; k < 40; k++) begin
         bit hold;
         hold = (k < 39) && ($urandom_range(0, 3) == 0);
         send(3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom_range(0, 1)), hold);
         if (!hold) idle_cycles($urandom_range(0, 6));
      end

      waited = 0;
      while (exp_q.size() > 0 && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d expected cycles left, expected 0", exp_q.size());
      end
      idle_cycles(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
